// File: rtl/alu_exe.sv
// alu_exe: MIPS execute-stage ALU.
// Combinational integer ops, HI/LO ownership, single-cycle multiply and a
// 32-iteration restoring divider that stalls the pipeline while it runs.
module alu_exe (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush,
  input  logic [5:0]  alucontrol,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [4:0]  sa,
  output logic [31:0] result,
  output logic        overflow,
  output logic        stall
);

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_LUI  = 6'b001000;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MTHI = 6'b010001;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_MTLO = 6'b010011;
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_MULU = 6'b011001;
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_a;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;

  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic signed [31:0] w_sum_s;
  logic signed [31:0] w_dif_s;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_is_div;
  logic               w_signed_div;
  logic               w_launch;
  logic               w_commit;
  logic        [32:0] w_sh;
  logic               w_ge;
  logic        [31:0] w_q_fin;
  logic        [31:0] w_r_fin;

  // Magnitude of an operand; unsigned operands pass through untouched.
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic en);
    return (en && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  // Reapply a sign to a divider magnitude.
  function automatic logic [31:0] fix_sign(input logic [31:0] m, input logic neg);
    return neg ? 32'(-m) : m;
  endfunction

  assign w_a_s        = srca;
  assign w_b_s        = srcb;
  assign w_sum_s      = w_a_s + w_b_s;
  assign w_dif_s      = w_a_s - w_b_s;
  assign w_prod_s     = w_a_s * w_b_s;
  assign w_prod_u     = {32'h0, srca} * {32'h0, srcb};
  assign w_is_div     = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
  assign w_signed_div = (alucontrol == OP_DIV);
  assign w_launch     = (r_state == S_IDLE) && valid_i && !flush && w_is_div;
  assign stall        = !rst && (w_launch || (r_state == S_BUSY));
  assign w_commit     = valid_i && !flush && !stall;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so 32 bits of the
  // difference are exact whenever the subtraction is taken.
  assign w_sh    = {r_rem, r_quo[31]};
  assign w_ge    = (w_sh >= {1'b0, r_dvs});
  assign w_q_fin = r_dz ? 32'hFFFF_FFFF : fix_sign(r_quo, r_neg_q);
  assign w_r_fin = r_dz ? r_a : fix_sign(r_rem, r_neg_r);

  // Combinational ALU result and signed-overflow flag.
  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (alucontrol)
      OP_ADD: begin
        result   = w_sum_s;
        overflow = (w_a_s[31] == w_b_s[31]) && (w_sum_s[31] != w_a_s[31]);
      end
      OP_ADDU: result = w_sum_s;
      OP_SUB: begin
        result   = w_dif_s;
        overflow = (w_a_s[31] != w_b_s[31]) && (w_dif_s[31] != w_a_s[31]);
      end
      OP_SUBU: result = w_dif_s;
      OP_AND:  result = srca & srcb;
      OP_OR:   result = srca | srcb;
      OP_XOR:  result = srca ^ srcb;
      OP_NOR:  result = ~(srca | srcb);
      OP_SLT:  result = {31'h0, (w_a_s < w_b_s)};
      OP_SLTU: result = {31'h0, (srca < srcb)};
      OP_SLL:  result = srcb << sa;
      OP_SRL:  result = srcb >> sa;
      OP_SRA:  result = 32'(w_b_s >>> sa);
      OP_LUI:  result = {srcb[15:0], 16'h0};
      OP_MFHI: result = r_hi;
      OP_MFLO: result = r_lo;
      default: result = 32'h0;
    endcase
  end

  // Divider next-state; a flush abandons whatever the divider is doing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Divider state and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_launch)
        r_cnt <= 5'd0;
      else if (r_state == S_BUSY)
        r_cnt <= r_cnt + 5'd1;
    end
  end

  // Divider datapath: latch magnitudes at launch, then iterate while busy.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_quo   <= mag32(w_a_s, w_signed_div);
      r_dvs   <= mag32(w_b_s, w_signed_div);
      r_rem   <= 32'h0;
      r_a     <= srca;
      r_dz    <= (srcb == 32'h0);
      r_neg_q <= w_signed_div && (srca[31] ^ srcb[31]);
      r_neg_r <= w_signed_div && srca[31];
    end else if (r_state == S_BUSY) begin
      r_rem <= w_ge ? (w_sh[31:0] - r_dvs) : w_sh[31:0];
      r_quo <= {r_quo[30:0], w_ge};
    end
  end

  // HI/LO: divider completion, moves and multiply results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if ((r_state == S_DONE) && !flush) begin
      r_hi <= w_r_fin;
      r_lo <= w_q_fin;
    end else if (w_commit) begin
      case (alucontrol)
        OP_MTHI: r_hi <= srca;
        OP_MTLO: r_lo <= srca;
        OP_MULT: {r_hi, r_lo} <= w_prod_s;
        OP_MULU: {r_hi, r_lo} <= w_prod_u;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exe.sv
// tb_alu_exe: table vectors, hand-written divider sequences and a random
// run against an arithmetic reference model of the execute stage.
module tb_alu_exe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush;
  logic [5:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [4:0]  sa;
  logic [31:0] result;
  logic        overflow;
  logic        stall;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  alu_exe dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush),
    .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .sa(sa),
    .result(result), .overflow(overflow), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the arithmetic definitions of each operation.
  function automatic void model_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                                    output logic [31:0] r, output logic ov);
    longint as_ = longint'($signed(a));
    longint bs_ = longint'($signed(b));
    longint t;
    r  = 32'h0;
    ov = 1'b0;
    case (op)
      6'h20, 6'h21: begin
        t = as_ + bs_;
        r = 32'(t);
        if (op == 6'h20) ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      6'h22, 6'h23: begin
        t = as_ - bs_;
        r = 32'(t);
        if (op == 6'h22) ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (as_ < bs_) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: r = 32'(longint'(b) * (64'sd1 <<< sh));
      6'h02: r = b / (32'd1 << sh);
      6'h03: r = 32'(bs_ >>> sh);
      6'h08: r = b * 32'h10000;
      6'h10: r = hi;
      6'h12: r = lo;
      default: r = 32'h0;
    endcase
  endfunction

  // Reference HI/LO update for the single-cycle writers.
  function automatic void model_hilo(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] hi, inout logic [31:0] lo);
    longint p;
    logic [63:0] pu;
    case (op)
      6'h11: hi = a;
      6'h13: lo = a;
      6'h18: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      6'h19: begin
        pu = 64'(a) * 64'(b);
        hi = pu[63:32];
        lo = pu[31:0];
      end
      default: ;
    endcase
  endfunction

  // Reference divide: truncating division, remainder follows the dividend.
  function automatic void model_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint as_ = longint'($signed(a));
    longint bs_ = longint'($signed(b));
    longint qq;
    longint rr;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == 6'h1A) begin
      qq = as_ / bs_;
      rr = as_ % bs_;
      q  = 32'(qq);
      r  = 32'(rr);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue a divide and hold it in EX until the stall drops; operands are
  // scrambled while busy. Returns with the bench in the cycle after DONE.
  task automatic run_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nstall);
    logic done = 1'b0;
    nstall     = 0;
    valid_i    = 1'b1;
    flush      = 1'b0;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (stall) nstall++;
      else done = 1'b1;
      step();
      if (!done) begin
        srca = $urandom;
        srcb = $urandom;
      end
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL div_timeout: stall still 1 after 40 cycles, expected release");
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    valid_i    = 1'b0;
    flush      = 1'b0;
    alucontrol = 6'h10;
    #2;
    check({tag, "_hi"}, {32'h0, result}, {32'h0, ehi});
    alucontrol = 6'h12;
    #1;
    check({tag, "_lo"}, {32'h0, result}, {32'h0, elo});
    step();
  endtask

  vec_t        vecs[$];
  logic [31:0] er;
  logic        eo;
  logic [31:0] eq;
  logic [31:0] erm;
  int          ns;
  logic [5:0]  ops[$];

  initial begin
    rst = 1'b1; valid_i = 1'b1; flush = 1'b0;
    alucontrol = 6'h1A; srca = 32'd9; srcb = 32'd2; sa = 5'd0;
    #1;
    step();
    #2;
    check("stall_in_reset", {63'h0, stall}, 64'h0);
    step();
    valid_i = 1'b0;
    rst     = 1'b0;
    step();
    read_hilo("reset", 32'h0, 32'h0);

    vecs.push_back('{"add_ovf",  6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1});
    vecs.push_back('{"addu",     6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0});
    vecs.push_back('{"add_neg",  6'h20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"add_ok",   6'h20, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{"sub_ovf",  6'h22, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{"subu",     6'h23, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0});
    vecs.push_back('{"sra",      6'h03, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0});
    vecs.push_back('{"srl",      6'h02, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0});
    vecs.push_back('{"sll",      6'h00, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0});
    vecs.push_back('{"slt",      6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0});
    vecs.push_back('{"sltu",     6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{"lui",      6'h08, 32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 1'b0});
    vecs.push_back('{"and",      6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0});
    vecs.push_back('{"or",       6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0});
    vecs.push_back('{"xor",      6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0});
    vecs.push_back('{"nor",      6'h27, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"illegal",  6'h3F, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b0});
    foreach (vecs[i]) begin
      valid_i = 1'b1; flush = 1'b0;
      alucontrol = vecs[i].op; srca = vecs[i].a; srcb = vecs[i].b; sa = vecs[i].sh;
      #2;
      check({vecs[i].name, "_res"}, {32'h0, result}, {32'h0, vecs[i].r});
      check({vecs[i].name, "_ovf"}, {63'h0, overflow}, {63'h0, vecs[i].ov});
      step();
    end

    // mult -3 x 5 with no stall
    valid_i = 1'b1; alucontrol = 6'h18; srca = 32'hFFFF_FFFD; srcb = 32'd5;
    #2;
    check("mult_stall", {63'h0, stall}, 64'h0);
    check("mult_res", {32'h0, result}, 64'h0);
    step();
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;
    read_hilo("mult", m_hi, m_lo);

    run_div(6'h1A, 32'hFFFF_FFF9, 32'd2, ns);
    check("div_stalls", ns, 33);
    read_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div(6'h1B, 32'd7, 32'd2, ns);
    check("divu_stalls", ns, 33);
    read_hilo("divu_7_2", 32'd1, 32'd3);
    run_div(6'h1B, 32'd5, 32'd0, ns);
    check("divz_stalls", ns, 33);
    read_hilo("divu_5_0", 32'd5, 32'hFFFF_FFFF);
    run_div(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, ns);
    read_hilo("div_min_m1", 32'h0, 32'h8000_0000);

    // flush mid-divide leaves HI/LO alone
    valid_i = 1'b1; alucontrol = 6'h11; srca = 32'h1111_1111; step();
    alucontrol = 6'h13; srca = 32'h2222_2222; step();
    m_hi = 32'h1111_1111; m_lo = 32'h2222_2222;
    alucontrol = 6'h1A; srca = 32'd100; srcb = 32'd7;
    for (int c = 0; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0; valid_i = 1'b0;
    #2;
    check("flush_stall", {63'h0, stall}, 64'h0);
    for (int c = 0; c < 40; c++) step();
    read_hilo("flush", m_hi, m_lo);

    // reset mid-divide clears HI/LO
    valid_i = 1'b1; alucontrol = 6'h1A; srca = 32'd100; srcb = 32'd7;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; valid_i = 1'b0;
    #2;
    check("rst_stall", {63'h0, stall}, 64'h0);
    for (int c = 0; c < 40; c++) step();
    m_hi = 32'h0; m_lo = 32'h0;
    read_hilo("rst", m_hi, m_lo);

    // random mix against the reference model
    ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h00, 6'h02, 6'h03, 6'h08, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19,
            6'h3E, 6'h01};
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        logic [5:0]  dop = $urandom_range(0, 1) ? 6'h1A : 6'h1B;
        logic [31:0] da  = $urandom;
        logic [31:0] db  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom >> $urandom_range(0, 31));
        run_div(dop, da, db, ns);
        check("rnd_div_stalls", ns, 33);
        model_div(dop, da, db, eq, erm);
        m_hi = erm; m_lo = eq;
      end else begin
        valid_i    = ($urandom_range(0, 7) != 0);
        flush      = ($urandom_range(0, 7) == 0);
        alucontrol = ops[$urandom_range(0, ops.size() - 1)];
        srca       = $urandom;
        srcb       = $urandom;
        sa         = 5'($urandom);
        #2;
        model_alu(alucontrol, srca, srcb, sa, m_hi, m_lo, er, eo);
        check("rnd_res", {26'h0, alucontrol, result}, {26'h0, alucontrol, er});
        check("rnd_ovf", {63'h0, overflow}, {63'h0, eo});
        check("rnd_stall", {63'h0, stall}, 64'h0);
        if (valid_i && !flush) model_hilo(alucontrol, srca, srcb, m_hi, m_lo);
        step();
      end
    end
    read_hilo("final", m_hi, m_lo);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
